// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and encodings for the iterative RV32M divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // funct3[1:0] of the M-extension divide group
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Radix-2 restoring DIV/DIVU/REM/REMU unit for the EX stage; stalls
//            the pipeline while iterating. Option: DIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_e,
    input  logic            kill_e,
    input  logic [1:0]      op_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    output logic            busy_e,
    output logic            done_e,
    output logic [XLEN-1:0] result_e
);

    localparam int              CNT_W      = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dvs;
    logic [XLEN-1:0]  r_src_a;
    logic [XLEN-1:0]  r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;

    logic             w_go;
    logic             w_early;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_abs;
    logic [XLEN-1:0]  w_b_abs;
    logic             w_b_zero;
    logic [XLEN-1:0]  w_rem_shift;
    logic [XLEN:0]    w_sub;
    logic             w_ge;
    logic [XLEN-1:0]  w_rem_nxt;
    logic [XLEN-1:0]  w_quo_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic [XLEN-1:0]  w_fix_result;

    assign w_go     = start_e & ~kill_e;
    assign w_a_neg  = op_is_signed(op_e) & src_a_e[XLEN-1];
    assign w_b_neg  = op_is_signed(op_e) & src_b_e[XLEN-1];
    assign w_a_abs  = w_a_neg ? -src_a_e : src_a_e;
    assign w_b_abs  = w_b_neg ? -src_b_e : src_b_e;
    assign w_b_zero = (src_b_e == '0);

`ifdef DIV_EARLY_OUT_EN
    logic            w_ovf;
    logic [XLEN-1:0] w_early_result;

    // Most-negative / -1: quotient is the dividend itself, remainder is zero
    assign w_ovf = op_is_signed(op_e)
                 & (src_a_e == {1'b1, {(XLEN-1){1'b0}}})
                 & (&src_b_e);
    assign w_early = w_b_zero | w_ovf;
    assign w_early_result = w_b_zero ? (op_is_rem(op_e) ? src_a_e : '1)
                                     : (op_is_rem(op_e) ? '0 : src_a_e);
`else
    assign w_early = 1'b0;
`endif

    // The partial remainder before the shift is always below the divisor, so
    // a set MSB guarantees the shifted value exceeds it.
    assign w_rem_shift = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_sub       = {1'b0, w_rem_shift} - {1'b0, r_dvs};
    assign w_ge        = r_rem[XLEN-1] | ~w_sub[XLEN];
    assign w_rem_nxt   = w_ge ? w_sub[XLEN-1:0] : w_rem_shift;

    assign w_quo_fix    = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix    = r_neg_r ? -r_rem : r_rem;
    assign w_fix_result = r_div_zero ? (r_is_rem ? r_src_a : '1)
                                     : (r_is_rem ? w_rem_fix : w_quo_fix);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_e      = 1'b0;
        done_e      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    busy_e      = 1'b1;
                    w_state_nxt = w_early ? DONE : CALC;
                end
            end
            CALC: begin
                busy_e = 1'b1;
                if (kill_e) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                busy_e      = 1'b1;
                w_state_nxt = kill_e ? IDLE : DONE;
            end
            DONE: begin
                done_e      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_src_a    <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_go) begin
                        r_rem      <= '0;
                        r_quo      <= w_a_abs;
                        r_dvs      <= w_b_abs;
                        r_src_a    <= src_a_e;
                        r_is_rem   <= op_is_rem(op_e);
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= w_b_zero;
`ifdef DIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_result <= w_early_result;
                        end
`endif
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    if (!kill_e) begin
                        r_result <= w_fix_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_e = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// Directed-vector bench for div_unit: stimulus pushes expected results into a
// scoreboard, a negedge monitor pops and compares on every done_e.
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_e;
    logic        kill_e;
    logic [1:0]  op_e;
    logic [31:0] src_a_e;
    logic [31:0] src_b_e;
    logic        busy_e;
    logic        done_e;
    logic [31:0] result_e;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_e  (start_e),
        .kill_e   (kill_e),
        .op_e     (op_e),
        .src_a_e  (src_a_e),
        .src_b_e  (src_b_e),
        .busy_e   (busy_e),
        .done_e   (done_e),
        .result_e (result_e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 34;
    endfunction

    // Monitor: every done_e must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done_e === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got result 0x%08h at cycle %0d, expected no done",
                         result_e, cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, " result"}, result_e, e.res);
                check({e.name, " cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int t;
        int lat;
        int n_busy;
        bit seen;
        @(negedge clk);
        op_e    = op;
        src_a_e = a;
        src_b_e = b;
        start_e = 1'b1;
        t       = cyc;
        lat     = latency(op, a, b);
        sb.push_back('{exp, t + lat, name});
        #1 check({name, " busy_issue"}, 32'(busy_e), 32'd1);
        n_busy = 1;
        seen   = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            start_e = 1'b0;
            if (done_e === 1'b1) begin
                seen = 1'b1;
                check({name, " busy_at_done"}, 32'(busy_e), 32'd0);
            end else if (busy_e === 1'b1) begin
                n_busy++;
            end
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " busy_cycles"}, 32'(n_busy), 32'(lat));
    endtask

    vec_t vecs[] = '{
        '{"divu_100_7",     DIV_OP_DIVU, 32'd100,       32'd7,         32'd14},
        '{"remu_100_7",     DIV_OP_REMU, 32'd100,       32'd7,         32'd2},
        '{"div_m7_2",       DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
        '{"rem_m7_2",       DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
        '{"div_7_m2",       DIV_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{"rem_7_m2",       DIV_OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1},
        '{"div_5_0",        DIV_OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF},
        '{"rem_m5_0",       DIV_OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB},
        '{"divu_m5_0",      DIV_OP_DIVU, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF},
        '{"remu_5_0",       DIV_OP_REMU, 32'd5,         32'd0,         32'd5},
        '{"div_ovf",        DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{"rem_ovf",        DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
        '{"divu_max_maxm1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1},
        '{"remu_max_big",   DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE}
    };

    initial begin
        int t;
        reset   = 1'b1;
        start_e = 1'b0;
        kill_e  = 1'b0;
        op_e    = 2'b00;
        src_a_e = '0;
        src_b_e = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy_e), 32'd0);
        check("reset done", 32'(done_e), 32'd0);
        check("reset result", result_e, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // start together with kill in IDLE must not launch anything
        @(negedge clk);
        op_e = DIV_OP_DIVU; src_a_e = 32'd100; src_b_e = 32'd7;
        start_e = 1'b1; kill_e = 1'b1;
        #1 check("start_kill busy", 32'(busy_e), 32'd0);
        @(negedge clk);
        start_e = 1'b0; kill_e = 1'b0;
        check("start_kill busy_next", 32'(busy_e), 32'd0);

        // kill mid-CALC, then a fresh op
        @(negedge clk);
        op_e = DIV_OP_DIVU; src_a_e = 32'd100; src_b_e = 32'd7;
        start_e = 1'b1;
        t = cyc;
        @(negedge clk);
        start_e = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        kill_e = 1'b1;
        @(negedge clk);
        kill_e = 1'b0;
        check("kill busy", 32'(busy_e), 32'd0);
        check("kill done", 32'(done_e), 32'd0);
        run_op("divu_9_3_after_kill", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3);

        // reset (with kill) mid-CALC, then a fresh op
        @(negedge clk);
        op_e = DIV_OP_DIV; src_a_e = 32'hFFFF_FFF9; src_b_e = 32'd2;
        start_e = 1'b1;
        t = cyc;
        @(negedge clk);
        start_e = 1'b0;
        while (cyc < t + 20) @(negedge clk);
        reset = 1'b1; kill_e = 1'b1;
        @(negedge clk);
        check("midreset busy", 32'(busy_e), 32'd0);
        check("midreset done", 32'(done_e), 32'd0);
        check("midreset result", result_e, 32'd0);
        reset = 1'b0; kill_e = 1'b0;
        run_op("divu_100_7_after_reset", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14);

        repeat (40) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
